// File: rtl/iq_capture_buffer.sv
// iq_capture_buffer: I/Q DAC formatting stage with head/tail packet capture.
// The DAC path reduces IN_W-bit filtered samples to OUT_W bits (one cycle of latency).
// An armed packet keeps its first HEAD_DEPTH samples and its last TAIL_DEPTH samples.
// A req/ack port reads the captured samples back at full precision.
// Optional build macro: IQCAP_ROUND_EN selects round-half-up with positive saturation
// instead of plain truncation on the DAC path.
module iq_capture_buffer #(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 10,
  parameter int HEAD_DEPTH = 64,
  parameter int TAIL_DEPTH = 64,
  parameter int LEN_W      = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   i_in,
  input  logic [IN_W-1:0]   q_in,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              arm,
  output logic              out_valid,
  output logic [OUT_W-1:0]  i_out,
  output logic [OUT_W-1:0]  q_out,
  output logic              busy,
  output logic              capture_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [IN_W-1:0]   rd_data
);

  localparam int HW = $clog2(HEAD_DEPTH);
  localparam int TW = $clog2(TAIL_DEPTH);
  localparam logic [HW:0]        HEAD_FULL  = (HW+1)'(HEAD_DEPTH);
  localparam logic [TW:0]        TAIL_FULL  = (TW+1)'(TAIL_DEPTH);
  localparam logic [LEN_W-1:0]   HEAD_LEN   = LEN_W'(HEAD_DEPTH);
  localparam logic [LEN_W-1:0]   HEAD_LAST  = LEN_W'(HEAD_DEPTH - 1);
  localparam logic [ADDR_W-1:0]  HEAD_LIM   = ADDR_W'(HEAD_DEPTH);
  localparam logic [ADDR_W-1:0]  STORE_LIM  = ADDR_W'(HEAD_DEPTH + TAIL_DEPTH);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, DONE} state_t;

  // Reduce one filtered sample to DAC width.
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] s);
`ifdef IQCAP_ROUND_EN
    logic [IN_W:0] half;
    logic [IN_W:0] sum;
    half = (IN_W+1)'(1) << (IN_W - OUT_W - 1);
    sum  = {s[IN_W-1], s} + half;
    // Only a positive input can carry into the sign bit when adding half an LSB.
    if (!sum[IN_W] && sum[IN_W-1])
      return {1'b0, {(OUT_W-1){1'b1}}};
    return sum[IN_W-1 -: OUT_W];
`else
    return s[IN_W-1 -: OUT_W];
`endif
  endfunction

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [TW-1:0]      ptr_reg, ptr_next;
  logic [HW:0]        head_cnt_reg, head_cnt_next;
  logic [TW:0]        tail_cnt_reg, tail_cnt_next;
  logic               done_next;

  logic               start, capturing, take, head_we;
  logic [LEN_W-1:0]   k, len_eff;
  logic [TW-1:0]      wptr;
  logic [HW:0]        head_base;
  logic [TW:0]        tail_base;

  logic [2*IN_W-1:0]  head_mem [HEAD_DEPTH];
  logic [2*IN_W-1:0]  tail_mem [TAIL_DEPTH];
  logic [2*IN_W-1:0]  head_rd_reg, tail_rd_reg;
  logic               sel_head_reg, sel_tail_reg, q_sel_reg;

  // A valid arm restarts the packet; a sample seen in the same cycle becomes k=0.
  assign start     = arm && (pkt_len != '0);
  assign capturing = (state_reg == HEAD) || (state_reg == BODY);
  assign take      = in_valid && (start || capturing);
  assign k         = start ? '0 : cnt_reg;
  assign len_eff   = start ? pkt_len : len_reg;
  assign wptr      = start ? '0 : ptr_reg;
  assign head_base = start ? '0 : head_cnt_reg;
  assign tail_base = start ? '0 : tail_cnt_reg;
  assign head_we   = take && (k < HEAD_LEN);
  assign busy      = capturing;

  // Capture FSM state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      cnt_reg      <= '0;
      ptr_reg      <= '0;
      head_cnt_reg <= '0;
      tail_cnt_reg <= '0;
      capture_done <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      head_cnt_reg <= head_cnt_next;
      tail_cnt_reg <= tail_cnt_next;
      capture_done <= done_next;
    end
  end

  // Next-state logic: restart on arm, then advance counters per accepted sample.
  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    ptr_next      = ptr_reg;
    head_cnt_next = head_cnt_reg;
    tail_cnt_next = tail_cnt_reg;
    done_next     = 1'b0;
    if (start) begin
      state_next    = HEAD;
      len_next      = pkt_len;
      cnt_next      = '0;
      ptr_next      = '0;
      head_cnt_next = '0;
      tail_cnt_next = '0;
    end
    if (take) begin
      cnt_next      = k + 1'b1;
      ptr_next      = wptr + 1'b1;
      head_cnt_next = (head_base == HEAD_FULL) ? head_base : head_base + 1'b1;
      tail_cnt_next = (tail_base == TAIL_FULL) ? tail_base : tail_base + 1'b1;
      if (k == len_eff - 1'b1) begin
        state_next = DONE;
        done_next  = 1'b1;
      end else if (k == HEAD_LAST) begin
        state_next = BODY;
      end
    end
  end

  // DAC path: one register stage, zero when no sample is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
    end else begin
      out_valid <= in_valid;
      i_out     <= in_valid ? reduce(i_in) : '0;
      q_out     <= in_valid ? reduce(q_in) : '0;
    end
  end

  // Sample storage writes; arrays are left unreset and hidden by the fill counts.
  always_ff @(posedge clk) begin
    if (head_we)
      head_mem[k[HW-1:0]] <= {q_in, i_in};
    if (take)
      tail_mem[wptr] <= {q_in, i_in};
  end

  // Read address decode: word index, then head or oldest-first tail entry.
  logic [ADDR_W-1:0] idx, j;
  logic [TW-1:0]     tail_addr;
  logic              in_head, head_ok, tail_ok;

  assign idx       = {1'b0, rd_addr[ADDR_W-1:1]};
  assign j         = idx - HEAD_LIM;
  assign in_head   = idx < HEAD_LIM;
  assign head_ok   = in_head && (idx < ADDR_W'(head_cnt_reg));
  assign tail_ok   = !in_head && (idx < STORE_LIM) && (j < ADDR_W'(tail_cnt_reg));
  assign tail_addr = ptr_reg - tail_cnt_reg[TW-1:0] + j[TW-1:0];

  // Registered array reads for the read port.
  always_ff @(posedge clk) begin
    if (rd_req) begin
      head_rd_reg <= head_mem[idx[HW-1:0]];
      tail_rd_reg <= tail_mem[tail_addr];
    end
  end

  // Read handshake and the validity gating that hides stale or out-of-range data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack       <= 1'b0;
      sel_head_reg <= 1'b0;
      sel_tail_reg <= 1'b0;
      q_sel_reg    <= 1'b0;
    end else begin
      rd_ack       <= rd_req;
      sel_head_reg <= rd_req && (state_reg == DONE) && head_ok;
      sel_tail_reg <= rd_req && (state_reg == DONE) && tail_ok;
      q_sel_reg    <= rd_addr[0];
    end
  end

  // Pick the gated word, then its I or Q half.
  logic [2*IN_W-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (sel_head_reg)
      rd_word = head_rd_reg;
    else if (sel_tail_reg)
      rd_word = tail_rd_reg;
    rd_data = q_sel_reg ? rd_word[2*IN_W-1:IN_W] : rd_word[IN_W-1:0];
  end

endmodule

// File: tb/tb_iq_capture_buffer.sv
// tb_iq_capture_buffer: directed self-checking bench for iq_capture_buffer.
// Expected DAC values follow IQCAP_ROUND_EN when the bench is built with it.
module tb_iq_capture_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] i_in, q_in;
  logic [15:0] pkt_len;
  logic        arm;
  logic        out_valid;
  logic [9:0]  i_out, q_out;
  logic        busy, capture_done;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ack;
  logic [11:0] rd_data;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  int done_k;

  iq_capture_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .i_in         (i_in),
    .q_in         (q_in),
    .pkt_len      (pkt_len),
    .arm          (arm),
    .out_valid    (out_valid),
    .i_out        (i_out),
    .q_out        (q_out),
    .busy         (busy),
    .capture_done (capture_done),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pkt(input logic [15:0] len);
    arm      = 1'b1;
    pkt_len  = len;
    in_valid = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input logic [11:0] i, input logic [11:0] q);
    in_valid = 1'b1;
    i_in     = i;
    q_in     = q;
    tick();
  endtask

  task automatic rd_chk(input logic [7:0] addr, input logic [11:0] exp);
    rd_req  = 1'b1;
    rd_addr = addr;
    tick();
    check($sformatf("rd_ack_%0d", addr), 32'(rd_ack), 32'd1);
    check($sformatf("rd_data_%0d", addr), 32'(rd_data), 32'(exp));
    $display("read addr=%0d data=%03h expect=%03h", addr, rd_data, exp);
  endtask

  initial begin
    logic [9:0] exp_i, exp_q;
    rst_n = 1'b0; in_valid = 1'b0; i_in = '0; q_in = '0;
    pkt_len = '0; arm = 1'b0; rd_req = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_ack", 32'(rd_ack), 0);
    rst_n = 1'b1;
    tick();

    // DAC path: full-scale positive and negative
    send(12'h7FF, 12'h800);
    exp_i = 10'h1FF;
    exp_q = 10'h200;
    check("dac1_valid", 32'(out_valid), 1);
    check("dac1_i", 32'(i_out), 32'(exp_i));
    check("dac1_q", 32'(q_out), 32'(exp_q));
    $display("dac in=7FF/800 out=%03h/%03h", i_out, q_out);

    // DAC path: small values where rounding differs from truncation
    send(12'h006, 12'hFFA);
`ifdef IQCAP_ROUND_EN
    exp_i = 10'h002;
    exp_q = 10'h3FF;
`else
    exp_i = 10'h001;
    exp_q = 10'h3FE;
`endif
    check("dac2_i", 32'(i_out), 32'(exp_i));
    check("dac2_q", 32'(q_out), 32'(exp_q));
    $display("dac in=006/FFA out=%03h/%03h", i_out, q_out);
    in_valid = 1'b0;
    tick();
    check("dac_idle_valid", 32'(out_valid), 0);
    check("dac_idle_i", 32'(i_out), 0);

    // Read before any capture returns zero
    rd_chk(8'd0, 12'h000);
    rd_req = 1'b0;

    // Packet of 300: I=k, Q=-k
    arm_pkt(16'd300);
    check("t3_busy", 32'(busy), 1);
    done_cnt = 0; done_k = -1;
    for (int k = 0; k < 300; k++) begin
      send(12'(k), 12'(-k));
      if (capture_done) begin done_cnt++; done_k = k; end
    end
    in_valid = 1'b0;
    check("t3_done_cnt", 32'(done_cnt), 1);
    check("t3_done_k", 32'(done_k), 299);
    check("t3_busy_end", 32'(busy), 0);
    tick();
    check("t3_done_pulse", 32'(capture_done), 0);
    rd_chk(8'd0,   12'h000);
    rd_chk(8'd127, 12'hFC1);
    rd_chk(8'd128, 12'd236);
    rd_chk(8'd200, 12'd272);
    rd_chk(8'd254, 12'd299);
    rd_chk(8'd255, 12'hED5);
    rd_req = 1'b0;
    tick();
    check("t3_ack_drop", 32'(rd_ack), 0);

    // Short packet of 40
    arm_pkt(16'd40);
    for (int k = 0; k < 40; k++) send(12'(k), 12'(-k));
    in_valid = 1'b0;
    check("t4_done", 32'(capture_done), 1);
    rd_chk(8'd78,  12'd39);
    rd_chk(8'd80,  12'h000);
    rd_chk(8'd127, 12'h000);
    rd_chk(8'd128, 12'h000);
    rd_chk(8'd130, 12'd1);
    rd_chk(8'd207, 12'hFD9);
    rd_chk(8'd208, 12'h000);
    rd_req = 1'b0;

    // Restart coincident with a sample at k=150
    arm_pkt(16'd300);
    done_cnt = 0; done_k = -1;
    for (int k = 0; k < 150; k++) begin
      send(12'(k), 12'(-k));
      if (capture_done) begin done_cnt++; done_k = k; end
    end
    arm = 1'b1; pkt_len = 16'd300;
    send(12'h400, 12'h000);
    arm = 1'b0;
    if (capture_done) begin done_cnt++; done_k = 1000; end
    check("t5_busy", 32'(busy), 1);
    for (int k = 1; k < 300; k++) begin
      send(12'(12'h400 + k), 12'(k));
      if (capture_done) begin done_cnt++; done_k = k; end
    end
    in_valid = 1'b0;
    check("t5_done_cnt", 32'(done_cnt), 1);
    check("t5_done_k", 32'(done_k), 299);
    rd_chk(8'd0,   12'h400);
    rd_chk(8'd1,   12'h000);
    rd_chk(8'd129, 12'd236);
    rd_chk(8'd254, 12'h52B);
    rd_req = 1'b0;

    // Reset in the middle of a capture
    arm_pkt(16'd300);
    for (int k = 0; k < 100; k++) send(12'(12'h100 + k), 12'(k));
    in_valid = 1'b1; i_in = 12'h1FF; q_in = 12'h0;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_i_out", 32'(i_out), 0);
    check("t6_done", 32'(capture_done), 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd_chk(8'd0, 12'h000);
    rd_chk(8'd2, 12'h000);
    rd_req = 1'b0;
    arm_pkt(16'd0);
    check("t6_len0_busy", 32'(busy), 0);
    send(12'h005, 12'h005);
    in_valid = 1'b0;
    check("t6_len0_done", 32'(capture_done), 0);
    check("t6_len0_busy2", 32'(busy), 0);
    rd_chk(8'd0, 12'h000);
    rd_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
